// File: rtl/logic_func_sweeper.sv
// logic_func_sweeper: walks a 2^N_IN-entry input sweep through a combinational
// function under test, captures its truth table and scores it against EXP_TT.
// Optional build macro: STOP_ON_ERR_EN ends the sweep at the first mismatch.
module logic_func_sweeper #(
  parameter int unsigned                N_IN   = 3,
  parameter logic [(1 << N_IN)-1:0]     EXP_TT = 8'hF8,
  parameter int unsigned                SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      resp,
  output logic [N_IN-1:0]           stim,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [N_IN:0]             err_count,
  output logic [N_IN-1:0]           first_err_idx,
  output logic [(1 << N_IN)-1:0]    captured_tt
);

  localparam int unsigned ERR_W = N_IN + 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_SAMPLE,
    S_FIN
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   settle_cnt;
  logic               mismatch_c;
  logic               last_c;

  assign mismatch_c = (resp != EXP_TT[stim]);
  assign last_c     = (stim == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_DRIVE;
      S_DRIVE:  next_state = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
      S_WAIT:   if (settle_cnt <= CNT_W'(1)) next_state = S_SAMPLE;
      S_SAMPLE: begin
`ifdef STOP_ON_ERR_EN
        if (last_c || mismatch_c) next_state = S_FIN;
        else                      next_state = S_DRIVE;
`else
        if (last_c) next_state = S_FIN;
        else        next_state = S_DRIVE;
`endif
      end
      S_FIN:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Settle counter: loaded while a vector is first driven, counts down in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == S_DRIVE) begin
      settle_cnt <= CNT_W'(SETTLE);
    end else if (state == S_WAIT) begin
      settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end

  // Status flags registered from the upcoming state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == S_DRIVE) || (next_state == S_WAIT) ||
              (next_state == S_SAMPLE);
      done <= (next_state == S_FIN);
    end
  end

  // Sweep datapath: vector index, capture, scoring and verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim          <= '0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      captured_tt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            stim          <= '0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            captured_tt   <= '0;
          end
        end
        S_SAMPLE: begin
          captured_tt[stim] <= resp;
          if (mismatch_c) begin
            err_count <= err_count + ERR_W'(1);
            if (err_count == '0) first_err_idx <= stim;
          end
          if (next_state == S_DRIVE) stim <= stim + N_IN'(1);
        end
        S_FIN: begin
          pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_func_sweeper.sv
// Randomized self-checking bench for logic_func_sweeper (default parameters).
// The function under test is a lookup of a per-sweep response table.
module tb_logic_func_sweeper;

  localparam int unsigned SETTLE  = 1;
  localparam int unsigned VEC_CYC = SETTLE + 2;
  localparam logic [7:0]  EXP_TT  = 8'hF8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       resp;
  logic [2:0] stim;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_err_idx;
  logic [7:0] captured_tt;

  logic [7:0] resp_tt = 8'h00;
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic_func_sweeper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .resp          (resp),
    .stim          (stim),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .captured_tt   (captured_tt)
  );

  always #5 clk = ~clk;

  // Function under test: arbitrary 3-input function given by its truth table
  assign resp = resp_tt[stim];

  // Count done pulses
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: score a response table against EXP_TT
  task automatic model(input logic [7:0] tt, output logic [7:0] cap, output int errs,
                       output int first, output int busy_cyc);
    logic [7:0] diff;
    logic [8:0] mask;
    diff  = tt ^ EXP_TT;
    errs  = $countones(diff);
    first = 0;
    for (int i = 7; i >= 0; i--) if (diff[i]) first = i;
    cap      = tt;
    busy_cyc = 8 * VEC_CYC;
`ifdef STOP_ON_ERR_EN
    if (errs > 0) begin
      mask     = (9'd1 << (first + 1)) - 9'd1;
      cap      = tt & mask[7:0];
      errs     = 1;
      busy_cyc = (first + 1) * VEC_CYC;
    end
`endif
  endtask

  // Entered at the negedge of the first busy cycle; runs to the cycle after done
  task automatic sweep_body(input logic [7:0] tt, input bit inject, input string tag);
    logic [7:0] e_cap;
    int e_err, e_first, e_busy, cycles, d0;
    model(tt, e_cap, e_err, e_first, e_busy);
    d0 = done_cnt;
    cycles = 0;
    while (busy === 1'b1 && cycles < 500) begin
      cycles++;
      if (inject && cycles == 10) start = 1'b1;
      if (inject && cycles == 11) start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(cycles), 32'(e_busy));
    check({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(done), 32'd0);
    check({tag, "_idle_gap"}, 32'(busy), 32'd0);
    check({tag, "_captured"}, 32'(captured_tt), 32'(e_cap));
    check({tag, "_err_count"}, 32'(err_count), 32'(e_err));
    check({tag, "_first_err"}, 32'(first_err_idx), 32'(e_first));
    check({tag, "_pass"}, 32'(pass), 32'(e_err == 0));
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic run_sweep(input logic [7:0] tt, input bit inject, input string tag);
    resp_tt = tt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sweep_body(tt, inject, tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stim"}, 32'(stim), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_first"}, 32'(first_err_idx), 32'd0);
    check({tag, "_cap"}, 32'(captured_tt), 32'd0);
  endtask

  initial begin
    int cycles, d0;
    logic [7:0] tt;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_sweep(EXP_TT, 1'b0, "golden");
    run_sweep(8'h00,  1'b0, "stuck0");
    run_sweep(8'hF0,  1'b0, "fault3");
    run_sweep(EXP_TT, 1'b1, "restart_ignored");
    run_sweep(8'hFF,  1'b0, "stuck1");

    // Start held high: back-to-back sweeps with one idle cycle between
    resp_tt = 8'hF0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    sweep_body(8'hF0, 1'b0, "b2b_first");
    @(negedge clk);
    check("b2b_relaunch", 32'(busy), 32'd1);
    check("b2b_cleared", 32'(captured_tt), 32'd0);
    start = 1'b0;
    resp_tt = EXP_TT;
    sweep_body(EXP_TT, 1'b0, "b2b_second");

    // Reset mid-WAIT of vector 4 aborts the sweep
    resp_tt = EXP_TT;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (cycles < 4 * VEC_CYC + 2) begin
      @(negedge clk);
      cycles++;
    end
    check("abort_stim", 32'(stim), 32'd4);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    rst_n = 1'b1;
    run_sweep(EXP_TT, 1'b0, "after_abort");

    // Random response tables
    for (int k = 0; k < 8; k++) begin
      tt = 8'($urandom);
      if (k == 0) tt = EXP_TT ^ 8'h80;
      run_sweep(tt, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
